// File: rtl/load_store_unit.sv
// Load/store unit between the RV32 execute stage and a word-only data memory.
// Checks alignment and range, extends sub-word loads, read-merge-writes SB/SH.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEM_CAPACITY = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] mem_A,
  output logic [DATA_WIDTH-1:0] mem_WD,
  output logic                  mem_WE,
  input  logic [DATA_WIDTH-1:0] mem_RD
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [1:0] {IDLE, MERGE, RESP} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] buf_q;
  logic [HALF_W-1:0]     wdata_q;
  logic                  half_q;

  logic                  accept;
  logic                  legal;
  logic                  misalign;
  logic                  oob;
  logic                  fault;
  logic                  sub_store;
  logic [DATA_WIDTH-1:0] live_idx;
  logic [DATA_WIDTH-1:0] latched_idx;
  logic [BYTE_W-1:0]     ld_byte;
  logic [HALF_W-1:0]     ld_half;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] merged;

  assign req_ready   = en && (state_q == IDLE);
  assign accept      = req_valid && req_ready;
  assign done        = en && (state_q == RESP);
  assign live_idx    = {2'b00, addr[DATA_WIDTH-1:2]};
  assign latched_idx = {2'b00, addr_q[DATA_WIDTH-1:2]};

  // Request decode and fault detection on the live request
  always_comb begin
    legal     = 1'b0;
    if (req_we) legal = funct3 inside {3'b000, 3'b001, 3'b010};
    else        legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    misalign  = ((funct3[1:0] == 2'b01) && addr[0]) ||
                ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    oob       = live_idx >= DATA_WIDTH'(MEM_CAPACITY);
    fault     = !legal || misalign || oob;
    sub_store = req_we && !funct3[1];
  end

  // Load lane extraction and extension
  always_comb begin
    ld_byte = mem_RD[{addr[1:0], 3'b000} +: BYTE_W];
    ld_half = mem_RD[{addr[1], 4'b0000} +: HALF_W];
    ld_data = '0;
    case (funct3)
      3'b000:  ld_data = {{(DATA_WIDTH-BYTE_W){ld_byte[BYTE_W-1]}}, ld_byte};
      3'b001:  ld_data = {{(DATA_WIDTH-HALF_W){ld_half[HALF_W-1]}}, ld_half};
      3'b010:  ld_data = mem_RD;
      3'b100:  ld_data = {{(DATA_WIDTH-BYTE_W){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(DATA_WIDTH-HALF_W){1'b0}}, ld_half};
      default: ld_data = '0;
    endcase
  end

  // Merge buffer with the latched byte/halfword patched in
  always_comb begin
    merged = buf_q;
    if (half_q) merged[{addr_q[1], 4'b0000} +: HALF_W] = wdata_q;
    else        merged[{addr_q[1:0], 3'b000} +: BYTE_W] = wdata_q[BYTE_W-1:0];
  end

  // Next state and memory port
  always_comb begin
    state_d = state_q;
    mem_WE  = 1'b0;
    mem_A   = live_idx;
    mem_WD  = wdata;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (fault) begin
            state_d = RESP;
          end else if (sub_store) begin
            state_d = MERGE;
          end else begin
            state_d = RESP;
            mem_WE  = req_we;
          end
        end
      end
      MERGE: begin
        mem_A  = latched_idx;
        mem_WD = merged;
        if (en) begin
          mem_WE  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      half_q  <= 1'b0;
      buf_q   <= '0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata[HALF_W-1:0];
        half_q  <= funct3[0];
        err     <= fault;
        if (fault)        rdata <= '0;
        else if (!req_we) rdata <= ld_data;
        if (!fault && sub_store) buf_q <= mem_RD;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: word memory environment plus a
// byte-level reference model of RV32 load/store semantics.
module tb_load_store_unit;

  localparam int unsigned DW  = 32;
  localparam int unsigned CAP = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    funct3;
  logic [DW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          done;
  logic [DW-1:0] rdata;
  logic          err;
  logic [DW-1:0] mem_A;
  logic [DW-1:0] mem_WD;
  logic          mem_WE;
  logic [DW-1:0] mem_RD;

  logic [DW-1:0] mem     [CAP];
  logic [DW-1:0] ref_mem [CAP];
  logic          pl_en;
  logic [3:0]    pl_idx;
  logic [DW-1:0] pl_data;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.DATA_WIDTH(DW), .MEM_CAPACITY(CAP)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .funct3(funct3), .addr(addr), .wdata(wdata), .done(done),
    .rdata(rdata), .err(err), .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE),
    .mem_RD(mem_RD)
  );

  always #5 clk = ~clk;

  // Word-only data memory with combinational read
  always_ff @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_WE && mem_A < DW'(CAP)) mem[mem_A[3:0]] <= mem_WD;
  end
  assign mem_RD = (mem_A < DW'(CAP)) ? mem[mem_A[3:0]] : '0;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [DW-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = 4'(idx); pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[idx] = d;
  endtask

  // Reference semantics: byte-addressed memory view over the word array
  task automatic model(input logic we, input logic [2:0] f3, input logic [DW-1:0] a,
                       input logic [DW-1:0] wd, output logic e, output logic [DW-1:0] rd,
                       output int lat, output int wes);
    int nbytes, idx, lane;
    logic [DW-1:0] w;
    longint v;
    bit ok;
    idx    = int'(a >> 2);
    lane   = int'(a % 4);
    nbytes = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    ok     = we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
    e      = !ok || (lane % nbytes != 0) || (idx >= int'(CAP));
    rd = '0; lat = 1; wes = 0;
    if (e) return;
    w = ref_mem[idx];
    if (!we) begin
      v = (longint'(w) >> (8 * lane)) % (longint'(1) << (8 * nbytes));
      if (f3 < 4 && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
        v = v - (longint'(1) << (8 * nbytes));
      rd = 32'(v);
    end else begin
      for (int b = 0; b < nbytes; b++) w[8*(lane+b) +: 8] = wd[8*b +: 8];
      ref_mem[idx] = w;
      lat = (nbytes == 4) ? 1 : 2;
      wes = 1;
    end
  endtask

  // One complete transaction: accept, wait for done, check result and memory
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [DW-1:0] a, input logic [DW-1:0] wd);
    logic e;
    logic [DW-1:0] rd;
    int lat, wes, obs_lat, obs_wes, idx;
    model(we, f3, a, wd, e, rd, lat, wes);
    idx = int'(a >> 2);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
    #1;
    check({tag, " ready"}, DW'(req_ready), 1);
    check({tag, " we_accept"}, DW'(mem_WE), DW'(we && !e && f3 == 3'b010));
    if (we && !e && f3 == 3'b010) check({tag, " idx"}, mem_A, a >> 2);
    obs_wes = (mem_WE === 1'b1) ? 1 : 0;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); funct3 = 3'($urandom);
    addr = $urandom; wdata = $urandom;
    #1;
    obs_lat = 1;
    while (done !== 1'b1 && obs_lat < 4) begin
      if (mem_WE === 1'b1) obs_wes++;
      @(negedge clk); #1;
      obs_lat++;
    end
    if (mem_WE === 1'b1) obs_wes++;
    check({tag, " latency"}, DW'(obs_lat), DW'(lat));
    check({tag, " err"}, DW'(err), DW'(e));
    if (!we || e) check({tag, " rdata"}, rdata, rd);
    check({tag, " we_cycles"}, DW'(obs_wes), DW'(wes));
    @(negedge clk); #1;
    check({tag, " done_pulse"}, DW'(done), 0);
    check({tag, " ready_again"}, DW'(req_ready), 1);
    if (!we || e) check({tag, " rdata_hold"}, rdata, rd);
    if (idx < int'(CAP)) check({tag, " mem"}, mem[idx], ref_mem[idx]);
  endtask

  initial begin
    logic          we_r;
    logic [2:0]    f3_r;
    logic [DW-1:0] a_r;
    logic          e_m;
    logic [DW-1:0] rd_m;
    int            lat_m, wes_m;

    rst = 1'b1; en = 1'b1; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b0;
    addr = '0; wdata = '0; pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    #1;
    check("reset done", DW'(done), 0);
    check("reset rdata", rdata, 0);
    check("reset err", DW'(err), 0);
    check("reset we", DW'(mem_WE), 0);
    check("reset ready", DW'(req_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < int'(CAP); i++) preload(i, $urandom);

    // Reset in the middle of a merge must abort the write
    preload(2, 32'hAABBCCDD);
    do_req("lw_w2", 1'b0, 3'b010, 32'h8, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b000; addr = 32'h8; wdata = 32'h55;
    #1;
    check("rst_sb accept_we", DW'(mem_WE), 0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("rst_sb merge_we", DW'(mem_WE), 1);
    rst = 1'b1;
    #1;
    check("rst_mid we", DW'(mem_WE), 0);
    check("rst_mid done", DW'(done), 0);
    check("rst_mid rdata", rdata, 0);
    check("rst_mid err", DW'(err), 0);
    check("rst_mid idle", DW'(req_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid word2", mem[2], 32'hAABBCCDD);
    check("rst_mid done_after", DW'(done), 0);

    // Loads
    preload(1, 32'h80FF7F01);
    do_req("lb6", 1'b0, 3'b000, 32'h6, 32'h0);
    check("lb6 value", rdata, 32'hFFFFFFFF);
    do_req("lbu6", 1'b0, 3'b100, 32'h6, 32'h0);
    check("lbu6 value", rdata, 32'h000000FF);
    do_req("lh6", 1'b0, 3'b001, 32'h6, 32'h0);
    check("lh6 value", rdata, 32'hFFFF80FF);
    do_req("lhu4", 1'b0, 3'b101, 32'h4, 32'h0);
    check("lhu4 value", rdata, 32'h00007F01);
    do_req("lw4", 1'b0, 3'b010, 32'h4, 32'h0);
    check("lw4 value", rdata, 32'h80FF7F01);

    // Sub-word stores
    preload(3, 32'h11223344);
    do_req("sb_d", 1'b1, 3'b000, 32'hD, 32'h000000AB);
    check("sb_d word3", mem[3], 32'h1122AB44);
    do_req("sh_e", 1'b1, 3'b001, 32'hE, 32'h0000BEEF);
    check("sh_e word3", mem[3], 32'hBEEFAB44);

    // Full-word store then read back
    do_req("sw_24", 1'b1, 3'b010, 32'h24, 32'hDEADBEEF);
    check("sw_24 word9", mem[9], 32'hDEADBEEF);
    do_req("lw_24", 1'b0, 3'b010, 32'h24, 32'h0);
    check("lw_24 value", rdata, 32'hDEADBEEF);

    // Faults
    do_req("f_lw2", 1'b0, 3'b010, 32'h2, 32'h0);
    check("f_lw2 err", DW'(err), 1);
    do_req("f_sh5", 1'b1, 3'b001, 32'h5, 32'h1234);
    check("f_sh5 err", DW'(err), 1);
    do_req("f_f3_011", 1'b0, 3'b011, 32'h0, 32'h0);
    check("f_f3_011 err", DW'(err), 1);
    do_req("f_sw28", 1'b1, 3'b010, 32'h28, 32'hCAFEF00D);
    check("f_sw28 err", DW'(err), 1);

    // Enable stall while in MERGE
    preload(4, 32'h01234567);
    model(1'b1, 3'b000, 32'h11, 32'h5A, e_m, rd_m, lat_m, wes_m);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b000; addr = 32'h11; wdata = 32'h5A;
    #1;
    check("stall accept_ready", DW'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0; en = 1'b0; addr = $urandom; wdata = $urandom;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall we", DW'(mem_WE), 0);
      check("stall done", DW'(done), 0);
      check("stall word4", mem[4], 32'h01234567);
      @(negedge clk);
    end
    en = 1'b1;
    #1;
    check("stall resume_we", DW'(mem_WE), 1);
    check("stall resume_idx", mem_A, 4);
    check("stall resume_done", DW'(done), 0);
    @(negedge clk); #1;
    check("stall done_after", DW'(done), 1);
    check("stall err", DW'(err), 0);
    check("stall word4_new", mem[4], 32'h01235A67);
    check("stall word4_model", mem[4], ref_mem[4]);
    @(negedge clk);

    // Randomised traffic against the reference model
    for (int n = 0; n < 80; n++) begin
      we_r = 1'($urandom);
      f3_r = 3'($urandom);
      a_r  = DW'($urandom_range(0, 47));
      if ($urandom_range(0, 1) == 1) a_r = a_r & ~DW'((f3_r[1:0] == 2'b01) ? 1 : (f3_r[1:0] == 2'b10) ? 3 : 0);
      do_req("rand", we_r, f3_r, a_r, $urandom);
    end

    for (int i = 0; i < int'(CAP); i++) check("final mem", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
